// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises CPU and debug-port accesses onto one single-port memory,
// waits out the fixed read latency and flags misaligned or out-of-range addresses.
module dmem_arbiter #(
    parameter int AW           = 10,
    parameter int MEM_LAT      = 1,
    parameter int CPU_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          halt_i,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    owner_t      owner, last_owner, winner;
    logic        take;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  wait_cnt;
    logic        cpu_elig, dbg_elig;
    logic        addr_err, is_cpu, is_dbg, in_done;
    logic [31:0] load_data;

    assign cpu_elig = cpu_req & ~halt_i;
    assign dbg_elig = dbg_req;
    assign addr_err = (lat_addr[1:0] != 2'b00) | (lat_addr[31:AW+2] != '0);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_nxt = state;
        winner    = OWN_CPU;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_elig && dbg_elig) begin
                    take   = 1'b1;
                    winner = (CPU_PRIORITY != 0 || last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
                end else if (cpu_elig) begin
                    take   = 1'b1;
                    winner = OWN_CPU;
                end else if (dbg_elig) begin
                    take   = 1'b1;
                    winner = OWN_DBG;
                end
                if (take) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = (addr_err || MEM_LAT == 1) ? DONE : WAIT;
            WAIT:    if (wait_cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DBG;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            wait_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            if (take) begin
                owner      <= winner;
                last_owner <= winner;
                lat_we     <= (winner == OWN_CPU) ? cpu_we    : dbg_we;
                lat_addr   <= (winner == OWN_CPU) ? cpu_addr  : dbg_addr;
                lat_wdata  <= (winner == OWN_CPU) ? cpu_wdata : dbg_wdata;
            end
            if (state == ISSUE)     wait_cnt <= LAT_M1;
            else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
        end
    end

    assign is_cpu  = (owner == OWN_CPU);
    assign is_dbg  = (owner == OWN_DBG);
    assign in_done = (state == DONE);

    // Stores and rejected accesses return zero; only a good load forwards memory data.
    assign load_data = (in_done && !lat_we && !addr_err) ? mem_rdata : '0;

    assign cpu_gnt    = (state == ISSUE) & is_cpu;
    assign dbg_gnt    = (state == ISSUE) & is_dbg;
    assign cpu_rvalid = in_done & is_cpu;
    assign dbg_rvalid = in_done & is_dbg;
    assign cpu_err    = in_done & is_cpu & addr_err;
    assign dbg_err    = in_done & is_dbg & addr_err;
    assign cpu_rdata  = is_cpu ? load_data : '0;
    assign dbg_rdata  = is_dbg ? load_data : '0;

    assign mem_en    = (state == ISSUE) & ~addr_err;
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = mem_en ? lat_addr[AW+1:2] : '0;
    assign mem_wdata = mem_en ? lat_wdata : '0;

    // Gated by rst so the CPU sees no stall while the arbiter itself is held in reset.
    assign cpu_stall = rst & cpu_req & ~(in_done & is_cpu);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LAT=1/round-robin and MEM_LAT=3/CPU priority),
// each with a latency-accurate memory model and an in-order completion scoreboard.
module tb_dmem_arbiter;

    typedef struct {
        bit          dbg;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_i;
    logic        cpu_req   [2];
    logic        cpu_we    [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic        cpu_gnt   [2];
    logic        cpu_rvalid[2];
    logic [31:0] cpu_rdata [2];
    logic        cpu_err   [2];
    logic        cpu_stall [2];
    logic        dbg_req   [2];
    logic        dbg_we    [2];
    logic [31:0] dbg_addr  [2];
    logic [31:0] dbg_wdata [2];
    logic        dbg_gnt   [2];
    logic        dbg_rvalid[2];
    logic [31:0] dbg_rdata [2];
    logic        dbg_err   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [9:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    logic [31:0] model [2][1024];
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LATG = (g == 0) ? 1 : 3;
        logic [31:0] mem  [1024];
        logic [31:0] pipe [3];
        exp_t sb [$];
        exp_t e;

        dmem_arbiter #(.AW(10), .MEM_LAT(LATG), .CPU_PRIORITY(g)) u_dut (
            .clk(clk), .rst(rst), .halt_i(halt_i),
            .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
            .cpu_wdata(cpu_wdata[g]), .cpu_gnt(cpu_gnt[g]), .cpu_rvalid(cpu_rvalid[g]),
            .cpu_rdata(cpu_rdata[g]), .cpu_err(cpu_err[g]), .cpu_stall(cpu_stall[g]),
            .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
            .dbg_wdata(dbg_wdata[g]), .dbg_gnt(dbg_gnt[g]), .dbg_rvalid(dbg_rvalid[g]),
            .dbg_rdata(dbg_rdata[g]), .dbg_err(dbg_err[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Single-port memory whose read data appears LATG cycles after mem_en; poison otherwise.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
                pipe[0] <= mem[mem_addr[g]];
            end else begin
                pipe[0] <= 32'hbad0_bad0;
            end
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[g] = pipe[LATG-1];

        always @(negedge clk) begin
            if (cpu_gnt[g] || dbg_gnt[g])
                check($sformatf("d%0d_gnt_excl", g), 32'(cpu_gnt[g] & dbg_gnt[g]), 0);
            if (!mem_en[g])
                check($sformatf("d%0d_mem_idle", g), 32'(mem_we[g]) | 32'(mem_addr[g]) | mem_wdata[g], 0);
            if (cpu_rvalid[g] || dbg_rvalid[g]) begin
                if (sb.size() == 0) begin
                    check($sformatf("d%0d_unexp_rvalid", g), 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("d%0d_rv_both", g), 32'(cpu_rvalid[g] & dbg_rvalid[g]), 0);
                    check($sformatf("d%0d_rv_owner", g), 32'(dbg_rvalid[g]), 32'(e.dbg));
                    check($sformatf("d%0d_rv_rdata", g), e.dbg ? dbg_rdata[g] : cpu_rdata[g], e.rdata);
                    check($sformatf("d%0d_rv_err", g), 32'(e.dbg ? dbg_err[g] : cpu_err[g]), 32'(e.err));
                    check($sformatf("d%0d_rv_other", g),
                          e.dbg ? (cpu_rdata[g] | 32'(cpu_err[g])) : (dbg_rdata[g] | 32'(dbg_err[g])), 0);
                end
            end
        end
    end

    function automatic logic get_gnt(input int d, input bit dbg);
        return dbg ? dbg_gnt[d] : cpu_gnt[d];
    endfunction

    function automatic logic get_rvalid(input int d, input bit dbg);
        return dbg ? dbg_rvalid[d] : cpu_rvalid[d];
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? gen_dut[0].sb.size() : gen_dut[1].sb.size();
    endfunction

    task automatic sb_flush();
        gen_dut[0].sb.delete();
        gen_dut[1].sb.delete();
    endtask

    task automatic push_exp(input int d, input bit dbg, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic [9:0] wa;
        wa      = addr[11:2];
        e.dbg   = dbg;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:12] != 20'h0);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) model[d][wa] = wdata;
            else    e.rdata = model[d][wa];
        end
        if (d == 0) gen_dut[0].sb.push_back(e);
        else        gen_dut[1].sb.push_back(e);
    endtask

    task automatic drive(input int d, input bit dbg, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (dbg) begin
            dbg_req[d] = 1'b1; dbg_we[d] = we; dbg_addr[d] = addr; dbg_wdata[d] = wdata;
        end else begin
            cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
        end
    endtask

    task automatic drop(input int d, input bit dbg);
        if (dbg) dbg_req[d] = 1'b0;
        else     cpu_req[d] = 1'b0;
    endtask

    // Starts at a negedge with the request already driven; returns at the rvalid negedge.
    task automatic finish(input int d, input bit dbg);
        int n;
        n = 0;
        @(negedge clk);
        while (!get_gnt(d, dbg) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!get_gnt(d, dbg)) begin
            check("gnt_timeout", 0, 1);
            drop(d, dbg);
            return;
        end
        drop(d, dbg);
        n = 0;
        @(negedge clk);
        while (!get_rvalid(d, dbg) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!get_rvalid(d, dbg)) check("rvalid_timeout", 0, 1);
    endtask

    task automatic access(input int d, input bit dbg, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        push_exp(d, dbg, we, addr, wdata);
        drive(d, dbg, we, addr, wdata);
        finish(d, dbg);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        sb_flush();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Both ports request continuously; expects four grants in arbitration order.
    task automatic tie_run(input int d);
        int k, n;
        bit exp_dbg;
        for (int i = 0; i < 4; i++) push_exp(d, (d == 0) ? i[0] : 1'b0, 1'b0, 32'h8, 32'h0);
        drive(d, 1'b0, 1'b0, 32'h8, 32'h0);
        drive(d, 1'b1, 1'b0, 32'h8, 32'h0);
        k = 0;
        n = 0;
        while (k < 4 && n < 60) begin
            @(negedge clk);
            n++;
            check("tie_stall", 32'(cpu_stall[d]), cpu_rvalid[d] ? 0 : 1);
            if (cpu_gnt[d] || dbg_gnt[d]) begin
                exp_dbg = (d == 0) ? k[0] : 1'b0;
                check($sformatf("tie_d%0d_gnt%0d_dbg", d, k), 32'(dbg_gnt[d]), 32'(exp_dbg));
                if (k == 3) begin
                    drop(d, 1'b0);
                    drop(d, 1'b1);
                end
                k++;
            end
        end
        if (k < 4) begin
            check("tie_timeout", 32'(k), 4);
            drop(d, 1'b0);
            drop(d, 1'b1);
        end
        n = 0;
        while (sb_size(d) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tie_drain", 32'(sb_size(d)), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst    = 1'b0;
        halt_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = 32'h0; cpu_wdata[d] = 32'h0;
            dbg_req[d] = 1'b0; dbg_we[d] = 1'b0; dbg_addr[d] = 32'h0; dbg_wdata[d] = 32'h0;
        end
        cpu_req[0] = 1'b1;
        #1;
        check("rst_stall", 32'(cpu_stall[0]), 0);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_gnt", 32'(cpu_gnt[0]), 0);
        check("rst_rvalid", 32'(cpu_rvalid[0]), 0);
        check("rst_mem_en", 32'(mem_en[0]), 0);
        check("rst_busy1", 32'(busy[1]), 0);
        cpu_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access(0, 1'b1, 1'b1, 32'h8, 32'h1234_5678);
        access(1, 1'b1, 1'b1, 32'h8, 32'h1234_5678);

        // CPU load with MEM_LAT=1: gnt at T+1, rvalid at T+2
        push_exp(0, 1'b0, 1'b0, 32'h8, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
        #1;
        check("t1_stall_T", 32'(cpu_stall[0]), 1);
        check("t1_gnt_T", 32'(cpu_gnt[0]), 0);
        @(negedge clk);
        check("t1_gnt", 32'(cpu_gnt[0]), 1);
        check("t1_stall_T1", 32'(cpu_stall[0]), 1);
        check("t1_mem_en", 32'(mem_en[0]), 1);
        check("t1_mem_we", 32'(mem_we[0]), 0);
        check("t1_mem_addr", 32'(mem_addr[0]), 2);
        drop(0, 1'b0);
        @(negedge clk);
        check("t1_rvalid", 32'(cpu_rvalid[0]), 1);
        check("t1_rdata", cpu_rdata[0], 32'h1234_5678);
        check("t1_stall_T2", 32'(cpu_stall[0]), 0);
        @(negedge clk);

        apply_reset();
        tie_run(0);
        tie_run(1);

        // DBG store with MEM_LAT=3, then CPU reads it back
        push_exp(1, 1'b1, 1'b1, 32'h10, 32'hdead_beef);
        drive(1, 1'b1, 1'b1, 32'h10, 32'hdead_beef);
        @(negedge clk);
        check("t3_gnt", 32'(dbg_gnt[1]), 1);
        check("t3_mem_en", 32'(mem_en[1]), 1);
        check("t3_mem_we", 32'(mem_we[1]), 1);
        check("t3_mem_addr", 32'(mem_addr[1]), 4);
        check("t3_mem_wdata", mem_wdata[1], 32'hdead_beef);
        drop(1, 1'b1);
        cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (mem_en[1]) cnt++;
            check($sformatf("t3_rvalid_c%0d", i), 32'(dbg_rvalid[1]), (i == 3) ? 1 : 0);
        end
        check("t3_mem_en_once", 32'(cnt), 0);
        access(1, 1'b0, 1'b0, 32'h10, 32'h0);

        // misaligned load: no memory strobe, error completion one cycle after grant
        push_exp(0, 1'b0, 1'b0, 32'h6, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h6, 32'h0);
        @(negedge clk);
        check("t4_gnt", 32'(cpu_gnt[0]), 1);
        check("t4_mem_en", 32'(mem_en[0]), 0);
        drop(0, 1'b0);
        @(negedge clk);
        check("t4_rvalid", 32'(cpu_rvalid[0]), 1);
        check("t4_err", 32'(cpu_err[0]), 1);
        check("t4_rdata", cpu_rdata[0], 32'h0);
        access(0, 1'b0, 1'b0, 32'h1000, 32'h0);
        access(0, 1'b1, 1'b1, 32'h1002, 32'h5555_aaaa);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);

        // halted CPU keeps stalling while DBG is served
        halt_i = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);
        check("t5_stall_a", 32'(cpu_stall[0]), 1);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0);
        check("t5_stall_b", 32'(cpu_stall[0]), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_cpu_gnt", 32'(cpu_gnt[0]), 0);
            check("t5_stall_hold", 32'(cpu_stall[0]), 1);
        end
        halt_i = 1'b0;
        push_exp(0, 1'b0, 1'b0, 32'h8, 32'h0);
        finish(0, 1'b0);

        // reset while waiting on memory: outputs clear at once, no late completion
        push_exp(1, 1'b0, 1'b0, 32'h8, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h8, 32'h0);
        @(negedge clk);
        check("t6_gnt", 32'(cpu_gnt[1]), 1);
        drop(1, 1'b0);
        @(negedge clk);
        check("t6_busy_wait", 32'(busy[1]), 1);
        rst = 1'b0;
        cpu_req[1] = 1'b1;
        #1;
        check("t6_busy_rst", 32'(busy[1]), 0);
        check("t6_mem_en_rst", 32'(mem_en[1]), 0);
        check("t6_stall_rst", 32'(cpu_stall[1]), 0);
        check("t6_rvalid_rst", 32'(cpu_rvalid[1]), 0);
        sb_flush();
        cpu_req[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_idle", 32'(busy[1]), 0);
        access(1, 1'b0, 1'b0, 32'h8, 32'h0);

        repeat (3) @(negedge clk);
        check("sb_empty0", 32'(sb_size(0)), 0);
        check("sb_empty1", 32'(sb_size(1)), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
